// File: rtl/pixel_packer.sv
// pixel_packer
// ------------
// Reduces each accepted camera pixel to PIX_W bits and packs WORD_W/PIX_W
// pixels into one word. Pixels are reduced either by comparing against a
// threshold or by keeping their top PIX_W bits. At the end of a line, a
// partially filled word is flushed with its unused high slots set to zero.
// Finished words are queued in a small show-ahead FIFO, which the downstream
// SDRAM write port drains using a valid/ready handshake.
//
// Ports
//   iCLK        pixel clock; all state changes on the rising edge
//   iRST_N      asynchronous active-low reset
//   iDATA       pixel value
//   iDVAL       pixel valid
//   iLVAL       line valid
//   iFVAL       frame valid
//   iMODE       0 = threshold, 1 = MSB truncate
//   iThreshold  binarisation threshold (unsigned compare, iDATA >= iThreshold)
//   oDATA       packed word at the FIFO head (0 when the FIFO is empty)
//   oDVAL       oDATA is valid
//   iREADY      downstream accepts oDATA this cycle
//   oOVF        sticky overflow; cleared by reset or by a frame start
//   oWORD_CNT   words written into the FIFO during the current frame
module pixel_packer #(
    parameter int DATA_W     = 12,
    parameter int PIX_W      = 1,
    parameter int WORD_W     = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 20
) (
    input  logic              iCLK,
    input  logic              iRST_N,
    input  logic [DATA_W-1:0] iDATA,
    input  logic              iDVAL,
    input  logic              iLVAL,
    input  logic              iFVAL,
    input  logic              iMODE,
    input  logic [DATA_W-1:0] iThreshold,
    output logic [WORD_W-1:0] oDATA,
    output logic              oDVAL,
    input  logic              iREADY,
    output logic              oOVF,
    output logic [CNT_W-1:0]  oWORD_CNT
);

    localparam int SLOTS  = WORD_W / PIX_W;
    localparam int SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int FILL_W = PTR_W + 1;

    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(SLOTS - 1);
    localparam logic [FILL_W-1:0] FULL_FILL = FILL_W'(FIFO_DEPTH);

    // Registered state
    logic                lval_q, lval_d;
    logic                fval_q, fval_d;
    logic [SLOT_W-1:0]   slot_q, slot_d;
    logic [WORD_W-1:0]   partial_q, partial_d;
    logic [WORD_W-1:0]   mem_q [FIFO_DEPTH];
    logic [WORD_W-1:0]   mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [FILL_W-1:0]   fill_q, fill_d;
    logic                ovf_q, ovf_d;
    logic [CNT_W-1:0]    word_cnt_q, word_cnt_d;
    logic [WORD_W-1:0]   out_data_q, out_data_d;
    logic                out_dval_q, out_dval_d;

    // Combinational intermediates
    logic                pix_accept;
    logic                line_end;
    logic                frame_start;
    logic [PIX_W-1:0]    pix_bits;
    logic [SLOT_W-1:0]   slot_base;
    logic [WORD_W-1:0]   partial_base;
    logic [WORD_W-1:0]   assembled;
    logic                push_req;
    logic [WORD_W-1:0]   push_word;
    logic                pop;
    logic                push_ok;

    // Packing datapath.
    // A frame start clears the slot and partial word first. A pixel accepted on
    // that same edge therefore lands in slot 0 of a clean word. A line-end
    // flush cannot coincide with an accepted pixel, because iLVAL is low during
    // a line end. If a frame start and a line end fall on the same edge, the
    // frame start wins and the stale partial word is discarded, not flushed.
    always_comb begin
        lval_d       = iLVAL;
        fval_d       = iFVAL;
        pix_accept   = iDVAL & iLVAL & iFVAL;
        line_end     = lval_q & ~iLVAL;
        frame_start  = ~fval_q & iFVAL;

        if (iMODE) begin
            pix_bits = iDATA[DATA_W-1 -: PIX_W];
        end else begin
            pix_bits = {PIX_W{iDATA >= iThreshold}};
        end

        slot_base    = frame_start ? '0 : slot_q;
        partial_base = frame_start ? '0 : partial_q;

        assembled = partial_base;
        for (int k = 0; k < SLOTS; k++) begin
            if (slot_base == SLOT_W'(k)) begin
                assembled[k*PIX_W +: PIX_W] = pix_bits;
            end
        end

        slot_d    = slot_base;
        partial_d = partial_base;
        push_req  = 1'b0;
        push_word = '0;

        if (pix_accept) begin
            if (slot_base == LAST_SLOT) begin
                push_req  = 1'b1;
                push_word = assembled;
                slot_d    = '0;
                partial_d = '0;
            end else begin
                slot_d    = slot_base + SLOT_W'(1);
                partial_d = assembled;
            end
        end else if (line_end && !frame_start && (slot_q != '0)) begin
            push_req  = 1'b1;
            push_word = partial_q;
            slot_d    = '0;
            partial_d = '0;
        end
    end

    // Output FIFO and frame statistics.
    // oDATA/oDVAL are registered copies of the head entry. The next head is
    // the word being pushed whenever the read pointer will land on the slot
    // being written this cycle. That case covers a push into an empty FIFO
    // and a push+pop at a fill level of one. A pop at full frees a slot, so a
    // simultaneous push is still accepted.
    always_comb begin
        pop     = out_dval_q & iREADY;
        push_ok = push_req & ((fill_q != FULL_FILL) | pop);

        mem_d = mem_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_word;
        end

        wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        fill_d   = fill_q + FILL_W'(push_ok) - FILL_W'(pop);

        ovf_d = frame_start ? 1'b0 : ovf_q;
        if (push_req && !push_ok) begin
            ovf_d = 1'b1;
        end

        word_cnt_d = (frame_start ? '0 : word_cnt_q) + CNT_W'(push_ok);

        out_dval_d = (fill_d != '0);
        if (!out_dval_d) begin
            out_data_d = '0;
        end else if (push_ok && (rd_ptr_d == wr_ptr_q)) begin
            out_data_d = push_word;
        end else begin
            out_data_d = mem_q[rd_ptr_d];
        end
    end

    // State registers. Reset discards everything, including queued words.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            lval_q     <= 1'b0;
            fval_q     <= 1'b0;
            slot_q     <= '0;
            partial_q  <= '0;
            mem_q      <= '{default: '0};
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fill_q     <= '0;
            ovf_q      <= 1'b0;
            word_cnt_q <= '0;
            out_data_q <= '0;
            out_dval_q <= 1'b0;
        end else begin
            lval_q     <= lval_d;
            fval_q     <= fval_d;
            slot_q     <= slot_d;
            partial_q  <= partial_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fill_q     <= fill_d;
            ovf_q      <= ovf_d;
            word_cnt_q <= word_cnt_d;
            out_data_q <= out_data_d;
            out_dval_q <= out_dval_d;
        end
    end

    assign oDATA     = out_data_q;
    assign oDVAL     = out_dval_q;
    assign oOVF      = ovf_q;
    assign oWORD_CNT = word_cnt_q;

endmodule

// File: tb/tb_pixel_packer.sv
// tb_pixel_packer
// ---------------
// Directed bench for pixel_packer. Two instances share one set of stimulus
// inputs: dut1 uses the default 1-bit pixels, and dut4 packs 4 bits per pixel.
// A vector table checks pixel reduction and packing on dut4. Hand-written
// sequences on dut1 cover flush, backpressure/overflow, frame start and
// asynchronous reset.
module tb_pixel_packer;

    logic        clk = 1'b0;
    logic        rstN;
    logic [11:0] data;
    logic        dval;
    logic        lval;
    logic        fval;
    logic        mode;
    logic [11:0] thr;
    logic        ready;

    logic [15:0] word1;
    logic        dval1;
    logic        ovf1;
    logic [19:0] cnt1;
    logic [15:0] word4;
    logic        dval4;
    logic        ovf4;
    logic [19:0] cnt4;

    int checks = 0;
    int passed = 0;

    typedef struct {
        logic        mode;
        logic [11:0] thr;
        logic [47:0] pix;
        logic [15:0] expWord;
    } vec_t;

    vec_t        vecs [5];
    logic [15:0] pats [5];

    // Free-running pixel clock, 10 time units per period
    always #5 clk = ~clk;

    pixel_packer dut1 (
        .iCLK       (clk),
        .iRST_N     (rstN),
        .iDATA      (data),
        .iDVAL      (dval),
        .iLVAL      (lval),
        .iFVAL      (fval),
        .iMODE      (mode),
        .iThreshold (thr),
        .oDATA      (word1),
        .oDVAL      (dval1),
        .iREADY     (ready),
        .oOVF       (ovf1),
        .oWORD_CNT  (cnt1)
    );

    pixel_packer #(.PIX_W(4)) dut4 (
        .iCLK       (clk),
        .iRST_N     (rstN),
        .iDATA      (data),
        .iDVAL      (dval),
        .iLVAL      (lval),
        .iFVAL      (fval),
        .iMODE      (mode),
        .iThreshold (thr),
        .oDATA      (word4),
        .oDVAL      (dval4),
        .iREADY     (ready),
        .oOVF       (ovf4),
        .oWORD_CNT  (cnt4)
    );

    // One comparison; counts it and reports a mismatch
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual === expected) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one valid pixel for exactly one clock edge
    task automatic applyStimulus(input logic [11:0] pix);
        data = pix;
        dval = 1'b1;
        tick();
    endtask

    // One edge without a valid pixel
    task automatic idle();
        dval = 1'b0;
        tick();
    endtask

    // Synchronous-looking reset pulse with line/frame low
    task automatic doReset();
        rstN  = 1'b0;
        dval  = 1'b0;
        lval  = 1'b0;
        fval  = 1'b0;
        ready = 1'b1;
        tick();
        tick();
        rstN = 1'b1;
        tick();
    endtask

    // Main directed sequence
    initial begin
        rstN  = 1'b0;
        data  = '0;
        dval  = 1'b0;
        lval  = 1'b0;
        fval  = 1'b0;
        mode  = 1'b0;
        thr   = 12'h100;
        ready = 1'b1;

        vecs[0] = '{1'b1, 12'h000, {12'hF00, 12'h3EF, 12'h2CD, 12'h1AB}, 16'hF321};
        vecs[1] = '{1'b0, 12'h100, {12'h000, 12'hFFF, 12'h0FF, 12'h100}, 16'h0F0F};
        vecs[2] = '{1'b0, 12'h000, {12'h000, 12'h123, 12'h001, 12'h000}, 16'hFFFF};
        vecs[3] = '{1'b1, 12'h000, {12'h7FF, 12'h800, 12'hFFF, 12'h000}, 16'h78F0};
        vecs[4] = '{1'b0, 12'hFFF, {12'hFFE, 12'hFFF, 12'hFFF, 12'hFFE}, 16'h0FF0};

        pats[0] = 16'h1234;
        pats[1] = 16'hABCD;
        pats[2] = 16'h00FF;
        pats[3] = 16'h8001;
        pats[4] = 16'h7777;

        // Reset state
        doReset();
        checkOutput("rst_dval", dval1, 1'b0);
        checkOutput("rst_data", word1, 16'h0000);
        checkOutput("rst_ovf", ovf1, 1'b0);
        checkOutput("rst_cnt", cnt1, 20'd0);

        // Threshold packing: alternating pixels -> 0x5555, valid for one cycle
        mode = 1'b0;
        thr  = 12'h100;
        lval = 1'b1;
        fval = 1'b1;
        for (int k = 0; k < 16; k++) begin
            applyStimulus((k % 2 == 0) ? 12'h200 : 12'h000);
            if (k == 14) checkOutput("thr_no_early_word", dval1, 1'b0);
        end
        checkOutput("thr_dval", dval1, 1'b1);
        checkOutput("thr_word", word1, 16'h5555);
        checkOutput("thr_cnt", cnt1, 20'd1);
        idle();
        checkOutput("thr_one_cycle", dval1, 1'b0);

        // End-of-line flush: 20 pixels -> 0xFFFF then 0x000F
        doReset();
        ready = 1'b0;
        lval  = 1'b1;
        fval  = 1'b1;
        for (int k = 0; k < 20; k++) applyStimulus(12'hFFF);
        dval = 1'b0;
        lval = 1'b0;
        tick();
        checkOutput("eol_cnt", cnt1, 20'd2);
        checkOutput("eol_dval", dval1, 1'b1);
        checkOutput("eol_word0", word1, 16'hFFFF);
        ready = 1'b1;
        tick();
        checkOutput("eol_word1_dval", dval1, 1'b1);
        checkOutput("eol_word1", word1, 16'h000F);
        tick();
        checkOutput("eol_drained", dval1, 1'b0);

        // Vector table on the 4-bit instance: reduction and packing order
        doReset();
        ready = 1'b1;
        lval  = 1'b1;
        fval  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            mode = vecs[i].mode;
            thr  = vecs[i].thr;
            for (int k = 0; k < 4; k++) applyStimulus(vecs[i].pix[k*12 +: 12]);
            checkOutput($sformatf("vec%0d_dval", i), dval4, 1'b1);
            checkOutput($sformatf("vec%0d_word", i), word4, vecs[i].expWord);
            idle();
        end
        checkOutput("vec_cnt", cnt4, 20'd5);
        checkOutput("vec_ovf", ovf4, 1'b0);

        // Backpressure and overflow: 5 words into a 4-deep FIFO
        doReset();
        ready = 1'b0;
        mode  = 1'b0;
        thr   = 12'h800;
        lval  = 1'b1;
        fval  = 1'b1;
        for (int w = 0; w < 5; w++) begin
            for (int k = 0; k < 16; k++) applyStimulus(pats[w][k] ? 12'hFFF : 12'h000);
            if (w == 3) begin
                checkOutput("bp_ovf_before", ovf1, 1'b0);
                checkOutput("bp_cnt_full", cnt1, 20'd4);
            end
        end
        checkOutput("bp_dval", dval1, 1'b1);
        checkOutput("bp_ovf", ovf1, 1'b1);
        checkOutput("bp_cnt", cnt1, 20'd4);
        dval  = 1'b0;
        ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("bp_drain%0d_dval", i), dval1, 1'b1);
            checkOutput($sformatf("bp_drain%0d_word", i), word1, pats[i]);
            tick();
        end
        checkOutput("bp_fifth_dropped", dval1, 1'b0);

        // Frame start: partial discarded, counters and overflow cleared
        for (int k = 0; k < 7; k++) applyStimulus(12'hFFF);
        dval = 1'b0;
        fval = 1'b0;
        tick();
        checkOutput("fs_ovf_held", ovf1, 1'b1);
        fval = 1'b1;
        for (int k = 0; k < 16; k++) begin
            applyStimulus(12'hFFF);
            if (k == 8) checkOutput("fs_no_stale_word", dval1, 1'b0);
        end
        checkOutput("fs_dval", dval1, 1'b1);
        checkOutput("fs_word", word1, 16'hFFFF);
        checkOutput("fs_cnt", cnt1, 20'd1);
        checkOutput("fs_ovf_clr", ovf1, 1'b0);
        idle();
        checkOutput("fs_single_word", dval1, 1'b0);

        // Asynchronous reset mid-word with a queued word pending
        ready = 1'b0;
        for (int k = 0; k < 16; k++) applyStimulus(12'hFFF);
        checkOutput("ar_pending", dval1, 1'b1);
        for (int k = 0; k < 9; k++) applyStimulus(12'hFFF);
        dval = 1'b0;
        #2;
        rstN = 1'b0;
        #1;
        checkOutput("ar_dval", dval1, 1'b0);
        checkOutput("ar_data", word1, 16'h0000);
        checkOutput("ar_cnt", cnt1, 20'd0);
        checkOutput("ar_ovf", ovf1, 1'b0);
        rstN  = 1'b1;
        ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            applyStimulus(12'hFFF);
            if (k == 14) checkOutput("ar_no_early_word", dval1, 1'b0);
        end
        checkOutput("ar_dval_after", dval1, 1'b1);
        checkOutput("ar_word_after", word1, 16'hFFFF);
        checkOutput("ar_cnt_after", cnt1, 20'd1);
        idle();
        checkOutput("ar_single_word", dval1, 1'b0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/pixel_packer.md
Name: pixel_packer

Overview:
Parametrised pixel-to-word packer between the camera colour/threshold stage and the SDRAM write FIFO port. It takes one pixel per qualified clock and reduces each pixel to PIX_W bits, either by threshold or by MSB truncation. It packs WORD_W/PIX_W pixels per word, flushes partial words at end of line, and buffers finished words in a small FIFO with a valid/ready handshake. It replaces the free-running shift register and divided write clock with a single-clock, frame-aligned, backpressure-aware packer.

Parameters:
DATA_W, 12, input pixel width
PIX_W, 1, packed bits per pixel; must divide WORD_W (1, 2, 4, 8 legal)
WORD_W, 16, output word width
FIFO_DEPTH, 4, output FIFO depth in words; power of two, at least 2
CNT_W, 20, width of per-frame word counter

Ports:
iCLK  in  1  pixel clock; all logic on rising edge
iRST_N  in  1  asynchronous active-low reset
iDATA  in  DATA_W  pixel value
iDVAL  in  1  pixel valid
iLVAL  in  1  line valid
iFVAL  in  1  frame valid
iMODE  in  1  0 = threshold, 1 = MSB truncate
iThreshold  in  DATA_W  binarisation threshold
oDATA  out  WORD_W  packed word at FIFO head
oDVAL  out  1  oDATA valid
iREADY  in  1  downstream accepts oDATA
oOVF  out  1  sticky overflow flag
oWORD_CNT  out  CNT_W  words written to FIFO in current frame

Behaviour:
- Reset (asynchronous, iRST_N=0): oDATA=0, oDVAL=0, oOVF=0, oWORD_CNT=0; slot counter, partial word, FIFO pointers and count, rLVAL and rFVAL all 0.
- Pixel accepted when iDVAL & iLVAL & iFVAL are all 1. Pixels outside that window are ignored.
- Pixel reduction:
  - iMODE=0: all PIX_W bits = 1 if iDATA >= iThreshold (unsigned), else all 0.
  - iMODE=1: iDATA[DATA_W-1 -: PIX_W].
- Packing order: the k-th pixel of a word occupies bits [k*PIX_W +: PIX_W], so the first pixel sits in the LSBs.
- Slot counter runs 0..SLOTS-1, where SLOTS = WORD_W/PIX_W.
- Word completion: on the edge that accepts the pixel in slot SLOTS-1, the assembled word is pushed to the FIFO, the slot counter is cleared, and the partial register is zeroed.
- End-of-line flush: a line end is detected when rLVAL=1 and iLVAL=0 (rLVAL is iLVAL registered).
  - If slot counter != 0, push the partial word with unused high slots = 0, then clear the slot counter.
  - If slot counter = 0, push nothing.
  - No pixel is accepted in the flush cycle, so a flush never collides with a completion.
- Frame start: detected when rFVAL=0 and iFVAL=1.
  - Partial word is discarded and slot counter cleared.
  - oWORD_CNT and oOVF cleared to 0.
  - A pixel accepted on that same edge is packed into slot 0 after the clear.
- FIFO:
  - Show-ahead: oDATA/oDVAL reflect the head, registered.
  - A word pushed into an empty FIFO appears with oDVAL=1 on the next cycle (latency 1 from the accepting edge).
  - Pop occurs when oDVAL & iREADY.
  - Push and pop in the same cycle are allowed at any fill level; count is unchanged.
- Full FIFO:
  - A push with count = FIFO_DEPTH and no simultaneous pop drops the new word, sets oOVF=1, and does not increment oWORD_CNT.
  - FIFO contents are unchanged.
  - A push with a simultaneous pop when full succeeds.
- oWORD_CNT increments by 1 per successful push and wraps at 2^CNT_W.
- oOVF stays set until reset or the next frame start.
- Mid-operation reset: all state is lost immediately, including FIFO contents; there is no flush on reset.

Test Plan:
- Threshold packing: PIX_W=1, WORD_W=16, iMODE=0, iThreshold=0x100, 16 accepted pixels alternating 0x200,0x000 starting 0x200, iREADY=1 -> one word 0x5555; oDVAL=1 for exactly one cycle, the cycle after the 16th pixel; oWORD_CNT=1.
- End-of-line flush: 20 pixels all 0xFFF in one line, then iLVAL falls -> words 0xFFFF then 0x000F; oWORD_CNT=2.
- Truncate mode: PIX_W=4, iMODE=1, pixels 0x1AB,0x2CD,0x3EF,0xF00 -> word 0xF321.
- Backpressure and overflow: FIFO_DEPTH=4, iREADY=0, 5 complete words -> oDVAL=1, oOVF=1, oWORD_CNT=4; release iREADY -> first 4 words drain in order and the 5th never appears.
- Frame start: 7 pixels, then iFVAL low→high, then 16 pixels of 0xFFF -> the partial is discarded, one word 0xFFFF is output, oWORD_CNT=1, and oOVF is cleared.
- Async reset mid-word: iRST_N pulsed low between clock edges after 9 pixels -> all outputs 0 immediately; the next 16 pixels produce exactly one word.
